stopwatch_bcd_counter: RTL and testbench
========================================

// Module: stopwatch_bcd_counter
// PURPOSE
//  Timebase and BCD time counter for the stopwatch; sits directly upstream of the per-digit
//  seven_seg_decoder instances and drives each decoder's 4-bit digit input.
//  Counts MM:SS.CC (minutes, seconds, centiseconds) under start/stop/clear button control.
//  All digit outputs are registered, hex 0-9 only, so decoders never see codes 10-15.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency; must be an exact multiple of TICK_HZ
//  TICK_HZ  100         count rate (centisecond tick); DIV = CLK_HZ/TICK_HZ, DIV >= 2
// PORTS
//  clk             in   1  system clock, rising edge
//  rst_n           in   1  asynchronous active-low reset
//  start_stop_btn  in   1  async, active high; each rising edge toggles run/pause
//  clear_btn       in   1  async, active high; rising edge zeroes count when not running
//  lap_btn         in   1  async, active high; used only with LAP_HOLD_EN, else ignored
//  cs_ones         out  4  centiseconds units, BCD 0-9
//  cs_tens         out  4  centiseconds tens, BCD 0-9
//  sec_ones        out  4  seconds units, BCD 0-9
//  sec_tens        out  4  seconds tens, BCD 0-5
//  min_ones        out  4  minutes units, BCD 0-9
//  min_tens        out  4  minutes tens, BCD 0-5
//  running         out  1  high in RUN state
//  rollover        out  1  one-cycle pulse when count wraps 59:59.99 -> 00:00.00
// BEHAVIOUR
//  - Reset (rst_n=0, async): all digits 0, running 0, rollover 0, prescaler 0, state IDLE,
//    synchronizers and edge regs 0, lap hold cleared. Reset mid-count discards everything.
//  - Each button: 2-flop synchronizer, then edge register; edge pulse = sync & ~prev.
//    State/count react on the 3rd rising clk edge after input first sampled high.
//    Held-high button produces exactly one edge; no debounce here (done at board level).
//  - FSM: IDLE (count zero, stopped), RUN, PAUSE.
//    IDLE  --start edge--> RUN
//    RUN   --start edge--> PAUSE (clear edge ignored in RUN)
//    PAUSE --start edge--> RUN ; PAUSE --clear edge--> IDLE (digits, prescaler -> 0)
//    IDLE  --clear edge--> IDLE (no-op)
//    Start and clear edge same cycle: in PAUSE clear wins -> IDLE, start dropped;
//    in IDLE/RUN start acts, clear ignored.
//  - Prescaler counts 0..DIV-1 only in RUN; holds in PAUSE; tick = (RUN && presc==DIV-1),
//    presc wraps to 0 on tick. Resume continues the partial centisecond.
//  - On tick, digits advance as a BCD cascade in the same clk edge: cs_ones 9->0 carries to
//    cs_tens; cs_tens 9->0 carries sec_ones; sec_ones 9->0 -> sec_tens; sec_tens 5->0 ->
//    min_ones; min_ones 9->0 -> min_tens; min_tens 5->0 = wrap.
//  - Wrap at 59:59.99: all digits 0, rollover=1 for that single cycle, stays in RUN.
//  - running is registered; it rises the same edge the state enters RUN.
//  - Count latency: first digit change DIV cycles after entering RUN from IDLE.
// CONFIGURATION
//  LAP_HOLD_EN defined: separate display registers sit between count and outputs.
//    lap edge in RUN toggles hold; while hold=1 outputs freeze, internal count continues.
//    lap edge clearing hold reloads outputs with the live count next edge.
//    Transition to IDLE (clear) and reset clear hold. Lap edge in IDLE/PAUSE ignored.
//    rollover reflects the internal count even while held.
//  LAP_HOLD_EN undefined: outputs driven directly by count regs; lap_btn unused, no hold logic.
// TESTING  (bench uses CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//  Reset release, start edge -> running=1 after 3 clk; cs_ones=1 exactly 10 clk after RUN entry.
//  Run 100 ticks from zero -> 00:01.00 (sec_ones=1, cs digits 0); 6000 ticks -> 01:00.00.
//  Preload via 359999 ticks to 59:59.99, one more tick -> all 0, rollover high one cycle, running=1.
//  Start, 4 clk into a tick period press stop, wait 50 clk, start -> next increment after 6 clk.
//  PAUSE + start & clear edges same cycle -> IDLE, digits 0, running=0; clear in RUN -> no change.
//  LAP_HOLD_EN: lap at 00:00.05, run 20 ticks -> outputs stay 00:00.05; lap again -> 00:00.25.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: centisecond timebase and MM:SS.CC BCD counter with
// start/stop and clear buttons, feeding the per-digit seven-segment decoders.
// Optional lap hold display registers are enabled by defining LAP_HOLD_EN.
module stopwatch_bcd_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop_btn,
    input  logic       clear_btn,
    input  logic       lap_btn,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // Per-digit terminal values, packed {min_tens .. cs_ones}.
    localparam logic [23:0] DIGIT_MAX = 24'h595999;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // One BCD digit step: returns {carry_out, next_digit}.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] dmax,
                                           input logic cin);
        if (!cin)
            return {1'b0, d};
        if (d == dmax)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Button synchronizers, bit 0 = start/stop, bit 1 = clear.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic          start_edge, clear_edge;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   count_q, count_d, count_inc;
    logic          running_q, running_d, rollover_q, rollover_d;
    logic          tick, carry, wrap;

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // Synchronizer chain and rising-edge detect for start and clear.
    always_comb begin
        sync1_d    = {clear_btn, start_stop_btn};
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        start_edge = sync2_q[0] & ~prev_q[0];
        clear_edge = sync2_q[1] & ~prev_q[1];
    end

    // BCD ripple cascade; only moves when a centisecond tick occurs.
    always_comb begin
        count_inc = count_q;
        carry     = tick;
        for (int i = 0; i < 6; i++) begin
            {carry, count_inc[4*i +: 4]} = bcd_inc(count_q[4*i +: 4], DIGIT_MAX[4*i +: 4], carry);
        end
        wrap = carry;
    end

    // Run/pause/idle control, prescaler and count next-state.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            count_d = count_inc;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_edge)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_edge)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // Clear beats a simultaneous start here.
                if (clear_edge) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    count_d = '0;
                end else if (start_edge) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                count_d = '0;
            end
        endcase
        running_d  = (state_d == ST_RUN);
        rollover_d = wrap;
    end

    // Control, count and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    assign running  = running_q;
    assign rollover = rollover_q;

`ifdef LAP_HOLD_EN
    logic        lap_s1_q, lap_s1_d, lap_s2_q, lap_s2_d, lap_prev_q, lap_prev_d;
    logic        lap_edge, hold_q, hold_d;
    logic [23:0] disp_q, disp_d;

    // Lap button sync, hold toggle, and display register that freezes while held.
    always_comb begin
        lap_s1_d   = lap_btn;
        lap_s2_d   = lap_s1_q;
        lap_prev_d = lap_s2_q;
        lap_edge   = lap_s2_q & ~lap_prev_q;
        hold_d     = hold_q;
        if ((state_q == ST_RUN) && lap_edge)
            hold_d = ~hold_q;
        if (state_d == ST_IDLE)
            hold_d = 1'b0;
        disp_d = hold_d ? disp_q : count_d;
    end

    // Lap hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_s1_q   <= 1'b0;
            lap_s2_q   <= 1'b0;
            lap_prev_q <= 1'b0;
            hold_q     <= 1'b0;
            disp_q     <= '0;
        end else begin
            lap_s1_q   <= lap_s1_d;
            lap_s2_q   <= lap_s2_d;
            lap_prev_q <= lap_prev_d;
            hold_q     <= hold_d;
            disp_q     <= disp_d;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = disp_q;
`else
    logic unused_lap;
    assign unused_lap = lap_btn;
    assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = count_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Testbench for stopwatch_bcd_counter (CLK_HZ=1000, TICK_HZ=100, DIV=10).
// Reference model keeps the time as a plain centisecond total.
module tb_stopwatch_bcd_counter;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXC    = 359999;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n, start_stop_btn, clear_btn, lap_btn;
    logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;

    int n_assert = 0;
    int n_fail   = 0;

    int       m_mode, m_cnt, m_ph, m_disp;
    bit       m_roll, m_hold;
    bit [3:0] sh, ch, lh;

    stopwatch_bcd_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop_btn(start_stop_btn),
        .clear_btn(clear_btn), .lap_btn(lap_btn),
        .cs_ones(cs_ones), .cs_tens(cs_tens), .sec_ones(sec_ones),
        .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .rollover(rollover)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] digits(input int c);
        int cs, s, m;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic reset_model();
        m_mode = M_IDLE; m_cnt = 0; m_ph = 0; m_disp = 0;
        m_roll = 0; m_hold = 0; sh = '0; ch = '0; lh = '0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        bit se, ce, le;
        int old_mode;
        sh = {sh[2:0], start_stop_btn};
        ch = {ch[2:0], clear_btn};
        lh = {lh[2:0], lap_btn};
        se = sh[2] & ~sh[3];
        ce = ch[2] & ~ch[3];
        le = lh[2] & ~lh[3];
        old_mode = m_mode;
        m_roll = 0;
        if (old_mode == M_RUN) begin
            if (m_ph == DIV - 1) begin
                m_ph = 0;
                if (m_cnt == MAXC) begin m_cnt = 0; m_roll = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                m_ph = m_ph + 1;
            end
        end
`ifdef LAP_HOLD_EN
        if (old_mode == M_RUN && le) m_hold = !m_hold;
`else
        if (le) m_hold = 0;
`endif
        if (old_mode == M_IDLE && se) m_mode = M_RUN;
        else if (old_mode == M_RUN && se) m_mode = M_PAUSE;
        else if (old_mode == M_PAUSE) begin
            if (ce) begin m_mode = M_IDLE; m_cnt = 0; m_ph = 0; end
            else if (se) m_mode = M_RUN;
        end
        if (m_mode == M_IDLE) m_hold = 0;
        if (!m_hold) m_disp = m_cnt;
    endtask

    task automatic check_all();
        logic [23:0] e;
        e = digits(m_disp);
        chk("cs_ones",  32'(cs_ones),  32'(e[3:0]));
        chk("cs_tens",  32'(cs_tens),  32'(e[7:4]));
        chk("sec_ones", 32'(sec_ones), 32'(e[11:8]));
        chk("sec_tens", 32'(sec_tens), 32'(e[15:12]));
        chk("min_ones", 32'(min_ones), 32'(e[19:16]));
        chk("min_tens", 32'(min_tens), 32'(e[23:20]));
        chk("running",  32'(running),  32'(m_mode == M_RUN));
        chk("rollover", 32'(rollover), 32'(m_roll));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst_n) reset_model();
            else model_edge();
            #1;
        end
        check_all();
    endtask

    // Hold buttons high until the edge at which the design reacts, then release.
    task automatic press(input bit s, input bit c, input bit l);
        start_stop_btn = s; clear_btn = c; lap_btn = l;
        step(3);
        start_stop_btn = 0; clear_btn = 0; lap_btn = 0;
    endtask

    initial begin
        int roll_seen;
        rst_n = 0; start_stop_btn = 0; clear_btn = 0; lap_btn = 0;
        reset_model();
        step(3);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_rollover", 32'(rollover), 32'd0);
        rst_n = 1;
        step(2);

        // Start latency: running rises on the 3rd edge.
        start_stop_btn = 1;
        step(2);
        chk("start_lat2", 32'(running), 32'd0);
        step(1);
        chk("start_lat3", 32'(running), 32'd1);
        start_stop_btn = 0;
        step(9);
        chk("first_inc_9", 32'(cs_ones), 32'd0);
        step(1);
        chk("first_inc_10", 32'(cs_ones), 32'd1);
        step(990);
        chk("t100_sec", 32'(sec_ones), 32'd1);
        chk("t100_cs", 32'({cs_tens, cs_ones}), 32'd0);
        step(59000);
        chk("t6000_min", 32'(min_ones), 32'd1);
        chk("t6000_sec", 32'({sec_tens, sec_ones}), 32'd0);

        // Preload 59:59.98 while paused, then run through the wrap.
        press(1, 0, 0);
        step(1);
        m_cnt = 359998;
        force dut.count_q = 24'h595998;
        step(1);
        release dut.count_q;
        step(1);
        press(1, 0, 0);
        roll_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (rollover === 1'b1) roll_seen++;
        end
        chk("roll_once", roll_seen, 1);
        chk("wrap_running", 32'(running), 32'd1);
        chk("wrap_min", 32'({min_tens, min_ones}), 32'd0);

        // Clear while running is ignored.
        step(1);
        press(0, 1, 0);
        chk("clear_in_run", 32'(running), 32'd1);

        // Start and clear together in PAUSE -> IDLE.
        step(1);
        press(1, 0, 0);
        step(1);
        press(1, 1, 0);
        chk("combo_running", 32'(running), 32'd0);
        chk("combo_digits", 32'({sec_tens, sec_ones, cs_tens, cs_ones}), 32'd0);

        // Pause 4 clk into a tick period, resume, next increment after 6 clk.
        step(1);
        press(1, 0, 0);
        step(1);
        press(1, 0, 0);
        chk("pause_running", 32'(running), 32'd0);
        step(50);
        chk("pause_hold", 32'(cs_ones), 32'd0);
        press(1, 0, 0);
        step(5);
        chk("resume_5", 32'(cs_ones), 32'd0);
        step(1);
        chk("resume_6", 32'(cs_ones), 32'd1);

`ifdef LAP_HOLD_EN
        // Lap hold at 00:00.05 for 20 ticks, then release shows the live count.
        step(1);
        press(1, 0, 0);
        step(1);
        press(0, 1, 0);
        step(1);
        press(1, 0, 0);
        step(52);
        press(0, 0, 1);
        step(200);
        chk("lap_hold_ones", 32'(cs_ones), 32'd5);
        chk("lap_hold_tens", 32'(cs_tens), 32'd0);
        press(0, 0, 1);
        chk("lap_rel_ones", 32'(cs_ones), 32'd5);
        chk("lap_rel_tens", 32'(cs_tens), 32'd2);
`endif

        // Asynchronous reset mid-count clears outputs without a clock edge.
        step(7);
        #2;
        rst_n = 0;
        #1;
        reset_model();
        check_all();
        chk("async_rst_running", 32'(running), 32'd0);
        step(2);
        rst_n = 1;
        step(1);

        // Random button activity with one reset pulse.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) start_stop_btn = ~start_stop_btn;
            if ($urandom_range(0, 7) == 0) clear_btn = ~clear_btn;
            if ($urandom_range(0, 7) == 0) lap_btn = ~lap_btn;
            rst_n = (i == 350) ? 1'b0 : 1'b1;
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
